instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Multi-cycle instruction memory that answers fetch requests from the fetch stage.
- It accepts one word-aligned fetch address at a time and returns the 32-bit instruction after a fixed, parameterised latency.
- It drives busy, which feeds the pipeline freeze, and supports flushing an in-flight request on a taken branch.
- A program-load write port lets the bench or boot logic fill the array.

Parameters:
ADDR_W, 10, word-address width; array holds 2**ADDR_W 32-bit words
LATENCY, 3, cycles from request acceptance to response; legal range 1..15

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-low; rst=0 resets immediately
fetch_req  input  1  fetch request; sampled only when busy=0
fetch_addr  input  32  byte address of the instruction; bits [1:0] ignored
flush  input  1  abort any outstanding request (taken branch)
prog_we  input  1  program-load write enable
prog_addr  input  ADDR_W  program-load word address
prog_data  input  32  program-load data
instr  output  32  returned instruction; held until the next response
instr_valid  output  1  one-cycle pulse marking a new instr
busy  output  1  request outstanding; drives freeze upstream

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, instr=32'h0, instr_valid=0, busy=0.
  - Memory contents are not cleared.
  - Reset mid-request aborts the request silently; no response follows the release of reset.
- States: IDLE, WAIT.
  - busy = (state==WAIT); it is decoded from the registered state.
- IDLE:
  - instr_valid is cleared each edge unless a response is being issued.
  - On an edge with fetch_req=1 and flush=0: latch word address fetch_addr[ADDR_W+1:2], cnt<=LATENCY-1, go to WAIT.
  - fetch_req=1 together with flush=1: the request is dropped and the block stays in IDLE.
- WAIT:
  - flush=1 on an edge: go to IDLE, cnt<=0, no response, instr keeps its old value.
  - Otherwise, if cnt!=0: cnt<=cnt-1.
  - Otherwise (cnt==0): instr<=mem[latched addr], instr_valid<=1, go to IDLE.
  - fetch_req is ignored while in WAIT.
- Latency and throughput:
  - A request accepted at edge k gives instr_valid=1 in the cycle after edge k+LATENCY.
  - busy=1 from edge k to edge k+LATENCY.
  - In the instr_valid cycle busy=0, so a new request can be accepted on that same edge. Maximum throughput is one fetch per LATENCY+1 cycles.
- instr_valid is high for exactly one cycle per response. instr holds its value between responses.
- Address range:
  - fetch_addr bits above ADDR_W+1 must be zero.
  - If they are nonzero, the response returns instr=32'h0 (NOP) with instr_valid=1 and normal timing.
- Program-load port:
  - prog_we writes mem[prog_addr]<=prog_data on the edge, in any state.
  - A write to the same word on the response edge is not visible to that response (the old value is returned); it is visible to later responses.
- Counter width is 4 bits; LATENCY is never reached by wrap-around.

Test Plan:
- Reset/hold: assert rst=0 for 3 cycles, then release -> instr=0, instr_valid=0, busy=0; with no fetch_req these outputs stay unchanged for 10 cycles.
- Basic fetch:
  - Stimulus: load mem[0..3]=32'hE3A00001, 32'hE2800002, 32'hE0811002, 32'hEAFFFFFE; request addr 32'h4 at edge k (LATENCY=3).
  - Required: busy=1 for 3 cycles; instr_valid pulses once in the cycle after edge k+3 with instr=32'hE2800002.
- Back-to-back: request addr 32'h8 in the same cycle instr_valid is high for addr 32'h4 -> request accepted; 32'hE0811002 returned 4 cycles after the first response.
- Flush:
  - Stimulus: request 32'hC, then flush=1 one cycle later.
  - Required: busy drops, no instr_valid pulse, instr keeps its previous value.
  - A new request for 32'h0 after the flush returns 32'hE3A00001.
- Misaligned and out-of-range:
  - fetch_addr=32'h7 returns mem[1]=32'hE2800002.
  - fetch_addr=32'h0001_0000 returns 32'h0 with a normal instr_valid pulse.
- Reset mid-request: assert rst=0 while busy=1 with cnt=1 -> outputs clear immediately; after rst=1 no instr_valid appears for 10 cycles.
- LATENCY=1 build: request 32'h0 -> busy high for exactly 1 cycle; instr_valid in the next cycle with instr=32'hE3A00001.

Source files
------------

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: multi-cycle instruction memory answering one fetch at a time after LATENCY cycles.
// Supports flush of the outstanding request and a program-load write port.
module instr_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              busy
);
  typedef enum logic {IDLE, WAIT} state_e;
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oor_q, oor_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [31:0]       mem [2**ADDR_W];
  logic              unused;
  assign unused = ^fetch_addr[1:0];
  // Array is never reset; a write on the response edge is not seen by that response.
  always_ff @(posedge clk)
    if (prog_we) mem[prog_addr] <= prog_data;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (fetch_req && !flush) begin
        addr_d  = fetch_addr[ADDR_W+1:2];
        oor_d   = |fetch_addr[31:ADDR_W+2];
        cnt_d   = 4'(LATENCY - 1);
        state_d = WAIT;
      end
    end else if (flush) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      instr_d = oor_q ? '0 : mem[addr_q];
      valid_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      oor_q   <= oor_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  assign busy        = (state_q == WAIT);
  assign instr       = instr_q;
  assign instr_valid = valid_q;
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: directed vector table, hand sequences and random traffic against a timeline model.
module tb_instr_mem_responder;
  localparam int LAT = 3;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        flush = 1'b0;
  logic        prog_we = 1'b0;
  logic [9:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [31:0] instr, i1_instr;
  logic        instr_valid, busy, i1_valid, i1_busy;
  int tests = 0;
  int fails = 0;

  instr_mem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .flush(flush),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr(instr), .instr_valid(instr_valid), .busy(busy));
  instr_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .flush(flush),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr(i1_instr), .instr_valid(i1_valid), .busy(i1_busy));

  always #5 clk = ~clk;

  // Timeline model: a pending request is due at an absolute edge number.
  logic [31:0] m_mem [1024];
  bit          m_pend = 0;
  int          m_due = 0;
  int unsigned m_addr = 0;
  logic [31:0] m_instr = '0;
  bit          m_valid = 0;
  int          edge_n = 0;

  task automatic model_reset();
    m_pend = 0; m_instr = '0; m_valid = 0;
  endtask

  task automatic model_step();
    bit nv = 0;
    if (!rst) model_reset();
    else begin
      if (m_pend) begin
        if (flush) m_pend = 0;
        else if (edge_n == m_due) begin
          m_instr = (m_addr >= 4096) ? 32'h0 : m_mem[(m_addr / 4) % 1024];
          nv = 1;
          m_pend = 0;
        end
      end else if (fetch_req && !flush) begin
        m_pend = 1; m_due = edge_n + LAT; m_addr = fetch_addr;
      end
      m_valid = nv;
    end
    if (prog_we) m_mem[prog_addr] = prog_data;
    edge_n++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit req, input logic [31:0] a, input bit fl,
                       input bit we, input logic [9:0] pa, input logic [31:0] pd);
    fetch_req = req; fetch_addr = a; flush = fl; prog_we = we; prog_addr = pa; prog_data = pd;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model_busy", {31'b0, busy}, {31'b0, m_pend});
    chk("model_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("model_instr", instr, m_instr);
  endtask

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          fl;
    logic [31:0] ei;
    bit          ev;
    bit          eb;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit req, logic [31:0] addr, bit fl, logic [31:0] ei, bit ev, bit eb);
    vec_t v;
    v.req = req; v.addr = addr; v.fl = fl; v.ei = ei; v.ev = ev; v.eb = eb;
    return v;
  endfunction

  initial begin
    logic [31:0] prog [4];
    prog[0] = 32'hE3A00001; prog[1] = 32'hE2800002; prog[2] = 32'hE0811002; prog[3] = 32'hEAFFFFFE;
    // basic fetch, back-to-back, flush, refetch, misaligned, out-of-range, dropped req+flush
    tbl.push_back(mk(1, 32'h4, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'h0, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE2800002, 1, 0));
    tbl.push_back(mk(1, 32'h8, 0, 32'hE2800002, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE2800002, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE2800002, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE0811002, 1, 0));
    tbl.push_back(mk(1, 32'hC, 0, 32'hE0811002, 0, 1));
    tbl.push_back(mk(0, 32'h0, 1, 32'hE0811002, 0, 0));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE0811002, 0, 0));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE0811002, 0, 0));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE0811002, 0, 0));
    tbl.push_back(mk(1, 32'h0, 0, 32'hE0811002, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE0811002, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE0811002, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE3A00001, 1, 0));
    tbl.push_back(mk(1, 32'h7, 0, 32'hE3A00001, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE3A00001, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE3A00001, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE2800002, 1, 0));
    tbl.push_back(mk(1, 32'h0001_0000, 0, 32'hE2800002, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE2800002, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'hE2800002, 0, 1));
    tbl.push_back(mk(0, 32'h0, 0, 32'h0, 1, 0));
    tbl.push_back(mk(1, 32'h0, 1, 32'h0, 0, 0));
    tbl.push_back(mk(0, 32'h0, 0, 32'h0, 0, 0));

    // reset held for 3 cycles, then 10 idle cycles
    repeat (3) cyc();
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_outputs", {instr[30:0], instr_valid, busy}, 33'h0);
    end

    for (int w = 0; w < 16; w++) begin
      drive(0, 0, 0, 1, 10'(w), (w < 4) ? prog[w] : $urandom);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].addr, tbl[i].fl, 0, 0, 0);
      cyc();
      chk($sformatf("vec%0d_instr", i), instr, tbl[i].ei);
      chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].eb});
    end

    // write on the response edge returns the old word; the next fetch sees the new one
    drive(1, 32'h0, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0); cyc(); cyc();
    drive(0, 0, 0, 1, 10'd0, 32'h12345678); cyc();
    chk("wr_resp_old", instr, 32'hE3A00001);
    chk("wr_resp_valid", {31'b0, instr_valid}, 32'h1);
    drive(1, 32'h0, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0); cyc(); cyc(); cyc();
    chk("wr_later_new", instr, 32'h12345678);

    // reset while busy with one wait cycle left
    drive(1, 32'h4, 0, 0, 0, 0); cyc();
    drive(0, 0, 0, 0, 0, 0); cyc();
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_valid", {31'b0, instr_valid}, 32'h0);
    chk("midrst_instr", instr, 32'h0);
    cyc(); cyc();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("postrst_no_valid", {31'b0, instr_valid}, 32'h0);
    end

    // LATENCY=1 instance
    drive(0, 0, 0, 1, 10'd0, 32'hE3A00001); cyc();
    drive(1, 32'h0, 0, 0, 0, 0); cyc();
    chk("lat1_busy", {31'b0, i1_busy}, 32'h1);
    chk("lat1_novalid", {31'b0, i1_valid}, 32'h0);
    drive(0, 0, 0, 0, 0, 0); cyc();
    chk("lat1_busy_drop", {31'b0, i1_busy}, 32'h0);
    chk("lat1_valid", {31'b0, i1_valid}, 32'h1);
    chk("lat1_instr", i1_instr, 32'hE3A00001);
    cyc();
    chk("lat1_pulse_end", {31'b0, i1_valid}, 32'h0);
    cyc(); cyc();

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      drive($urandom_range(0, 9) < 6, a, $urandom_range(0, 6) == 0,
            $urandom_range(0, 4) == 0, 10'($urandom_range(0, 15)), $urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
